// File: rtl/mem_stream_pkg.sv
// -----------------------------------------------------------------------------
// mem_stream_pkg
// Shared types and constants for the data-RAM port B streaming reader.
//   state_t       : reader FSM states
//   ADDR_W/DATA_W : data RAM address / word widths
//   stream_word_t : one stream beat (data word plus last flag)
// -----------------------------------------------------------------------------
package mem_stream_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } stream_word_t;

endpackage

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Synchronous show-ahead FIFO: the head entry is visible on o_rdata whenever
// o_empty is low. DEPTH must be a power of two. Push while full and pop while
// empty are ignored.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears contents)
//   i_push/i_wdata : write strobe and data
//   i_pop          : advance the head
//   o_rdata        : head entry
//   o_count        : occupancy, 0..DEPTH
//   o_empty/o_full : status flags
// -----------------------------------------------------------------------------
module stream_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == {(PTR_W+1){1'b0}});
   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {(PTR_W+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
// Read-only streaming engine on data RAM port B. On start it reads word_count
// consecutive words from base_addr (address wraps modulo 2^ADDR_W), absorbs the
// RAM read latency with a tag shift register and delivers the words in order on
// a valid/ready stream, flagging the final word with out_last.
// Ports:
//   CLK, RST              : clock, asynchronous active-low reset
//   start, base_addr,
//   word_count            : transfer command, sampled only while idle
//   busy, done            : transfer in progress / one-cycle end pulse
//   address_b, mem_data_b : RAM port B read address (registered) and read data
//   out_valid, out_ready,
//   out_data, out_last    : output stream
// -----------------------------------------------------------------------------
module mem_stream_reader #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 24,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] address_b,
   input  logic [DATA_W-1:0] mem_data_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   import mem_stream_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int FW    = DATA_W + 1;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_issue_addr;
   logic [ADDR_W-1:0]   r_remaining;
   logic [ADDR_W-1:0]   r_address_b;
   logic [ADDR_W-1:0]   w_issue_addr;
   logic [ADDR_W-1:0]   w_remaining_src;
   // Stage 0 lines up with address_b; stage RD_LAT lines up with mem_data_b.
   logic [RD_LAT:0]     r_tag_v;
   logic [RD_LAT:0]     r_tag_last;
   logic                r_busy;
   logic                r_done;
   logic                w_issue;
   logic                w_issue_last;
   logic                w_push;
   logic                w_pop;
   logic                w_credit_ok;
   logic                w_out_valid;
   logic                w_out_last;
   logic [CNT_W-1:0]    w_inflight;
   logic [CNT_W-1:0]    w_fifo_count;
   logic                w_fifo_empty;
   logic                w_fifo_full;
   logic [FW-1:0]       w_fifo_rdata;

   assign w_out_valid = !w_fifo_empty;
   assign w_out_last  = w_out_valid && w_fifo_rdata[0];
   assign w_pop       = w_out_valid && out_ready;
   assign w_push      = r_tag_v[RD_LAT] && !w_fifo_full;
   assign w_inflight  = CNT_W'($countones(r_tag_v));
   // A pop in this cycle frees its slot for an issue in the same cycle, which
   // is what sustains one word per cycle with a FIFO only RD_LAT+2 deep.
   assign w_credit_ok = ({1'b0, w_inflight} + {1'b0, w_fifo_count})
                        < ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(w_pop));

   assign busy      = r_busy;
   assign done      = r_done;
   assign address_b = r_address_b;
   assign out_valid = w_out_valid;
   assign out_last  = w_out_last;
   assign out_data  = w_out_valid ? w_fifo_rdata[FW-1:1] : {DATA_W{1'b0}};

   // Next-state and read-issue decision; the first read issues on the start edge.
   always_comb begin
      w_next_state    = r_state;
      w_issue         = 1'b0;
      w_issue_last    = 1'b0;
      w_issue_addr    = r_issue_addr;
      w_remaining_src = r_remaining;
      case (r_state)
         IDLE: begin
            w_issue_addr    = base_addr;
            w_remaining_src = word_count;
            if (start) begin
               if (word_count == {ADDR_W{1'b0}}) begin
                  w_next_state = DONE;
               end else begin
                  w_issue      = 1'b1;
                  w_issue_last = (word_count == ADDR_W'(1));
                  w_next_state = w_issue_last ? DRAIN : RUN;
               end
            end else begin
               w_next_state = IDLE;
            end
         end
         RUN: begin
            if (w_credit_ok) begin
               w_issue      = 1'b1;
               w_issue_last = (r_remaining == ADDR_W'(1));
               w_next_state = w_issue_last ? DRAIN : RUN;
            end else begin
               w_next_state = RUN;
            end
         end
         DRAIN: begin
            if (w_pop && w_out_last) begin
               w_next_state = DONE;
            end else begin
               w_next_state = DRAIN;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM state plus registered busy/done decoded from the next state.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == RUN) || (w_next_state == DRAIN);
         r_done  <= (w_next_state == DONE);
      end
   end

   // Read address and transfer counters; address_b holds when nothing issues.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_address_b  <= {ADDR_W{1'b0}};
         r_issue_addr <= {ADDR_W{1'b0}};
         r_remaining  <= {ADDR_W{1'b0}};
      end else if (w_issue) begin
         r_address_b  <= w_issue_addr;
         r_issue_addr <= w_issue_addr + ADDR_W'(1);
         r_remaining  <= w_remaining_src - ADDR_W'(1);
      end
   end

   // Tag shift register tracking which RAM output cycles carry requested data.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_tag_v    <= {(RD_LAT+1){1'b0}};
         r_tag_last <= {(RD_LAT+1){1'b0}};
      end else begin
         r_tag_v    <= {r_tag_v[RD_LAT-1:0], w_issue};
         r_tag_last <= {r_tag_last[RD_LAT-1:0], w_issue_last};
      end
   end

   stream_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_wdata ({mem_data_b, r_tag_last[RD_LAT]}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

endmodule

// File: tb/tb_mem_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_stream_reader
// Directed bench for mem_stream_reader with a two-cycle registered RAM model.
// Inputs change and outputs are checked on the falling clock edge; stream
// handshakes are logged on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stream_reader;

   localparam int AW    = 18;
   localparam int DW    = 24;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] word_count = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] address_b;
   logic [DW-1:0] mem_data_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;

   always #5 clk = ~clk;

   mem_stream_reader #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LAT     (2),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .address_b  (address_b),
      .mem_data_b (mem_data_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   // RAM model: registered address, registered data (two-cycle read).
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] ram_addr_q = '0;
   always @(posedge clk) begin
      ram_addr_q <= address_b;
      mem_data_b <= mem[ram_addr_q];
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [DW-1:0] q_data [$];
   logic          q_last [$];
   int            q_cyc  [$];

   // Handshake logger; cyc is the index of the cycle that just ended.
   always @(posedge clk) begin
      if (out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_last.push_back(out_last);
         q_cyc.push_back(cyc);
      end
      cyc <= cyc + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clear_log();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic wait_done(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) check_val({tag, "_done_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic check_stream(input string tag, input logic [AW-1:0] b, input int cnt);
      logic [AW-1:0] a;
      int n;
      check_val({tag, "_count"}, 64'(q_data.size()), 64'(cnt));
      n = (q_data.size() < cnt) ? q_data.size() : cnt;
      for (int i = 0; i < n; i++) begin
         a = b + AW'(i);
         check_val($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(mem[a]));
         check_val($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == cnt - 1));
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c, output int t0);
      @(negedge clk);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      t0         = cyc;
   endtask

   function automatic logic [45:0] out_vec();
      return {busy, done, out_valid, out_last, out_data, address_b};
   endfunction

   initial begin
      int t0;
      int issued;
      int seen_valid;
      logic [AW-1:0] prev;

      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = 24'(i) ^ 24'hC35000;
      end
      mem[18'h00100] = 24'h0000A1;
      mem[18'h00101] = 24'h0000A2;
      mem[18'h00102] = 24'h0000A3;
      mem[18'h00103] = 24'h0000A4;

      // Reset state, then 20 idle cycles with start low
      repeat (3) @(negedge clk);
      check_val("in_reset", 64'(out_vec()), 64'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check_val($sformatf("idle%0d", k), 64'(out_vec()), 64'd0);
      end

      // Basic transfer with exact cycle timing
      out_ready = 1'b1;
      clear_log();
      do_start(18'h00100, 18'd4, t0);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k <= 4) check_val($sformatf("basic_addr%0d", k), 64'(address_b), 64'(18'h00100 + k - 1));
         check_val($sformatf("basic_busy%0d", k), 64'(busy), 64'(k <= 7));
         check_val($sformatf("basic_done%0d", k), 64'(done), 64'(k == 8));
      end
      check_stream("basic", 18'h00100, 4);
      for (int i = 0; i < q_cyc.size(); i++) begin
         check_val($sformatf("basic_cyc%0d", i), 64'(q_cyc[i] - t0), 64'(4 + i));
      end

      // Backpressure: ready low for 12 cycles, then drain 16 words
      out_ready = 1'b0;
      clear_log();
      prev = address_b;
      issued = 0;
      do_start(18'h00200, 18'd16, t0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (address_b != prev) issued++;
         prev = address_b;
      end
      check_val("bp_issued", 64'(issued), 64'(DEPTH));
      check_val("bp_valid", 64'(out_valid), 64'd1);
      check_val("bp_held", 64'(q_data.size()), 64'd0);
      out_ready = 1'b1;
      wait_done("bp", 200);
      check_stream("bp", 18'h00200, 16);

      // Address wrap at the top of the address space
      clear_log();
      do_start(18'h3FFFE, 18'd3, t0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         check_val($sformatf("wrap_addr%0d", k), 64'(address_b), 64'(AW'(18'h3FFFE + k - 1)));
      end
      wait_done("wrap", 50);
      check_stream("wrap", 18'h3FFFE, 3);

      // Count zero: immediate done, no stream output, busy stays low
      clear_log();
      seen_valid = 0;
      do_start(18'h00010, 18'd0, t0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (out_valid) seen_valid++;
         if (k == 1) check_val("zero_done1", 64'(done), 64'd1);
         if (k == 2) check_val("zero_done2", 64'(done), 64'd0);
         check_val($sformatf("zero_busy%0d", k), 64'(busy), 64'd0);
      end
      check_val("zero_valid", 64'(seen_valid), 64'd0);
      check_val("zero_words", 64'(q_data.size()), 64'd0);

      // Start pulse mid-transfer is ignored
      clear_log();
      do_start(18'h00300, 18'd10, t0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            base_addr  = 18'h00050;
            word_count = 18'd5;
            start      = 1'b1;
         end
         if (k == 4) start = 1'b0;
      end
      wait_done("ign", 100);
      repeat (10) @(negedge clk);
      check_stream("ign", 18'h00300, 10);
      check_val("ign_busy_after", 64'(busy), 64'd0);

      // Reset after 3 of 8 words
      clear_log();
      do_start(18'h00400, 18'd8, t0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (q_data.size() >= 3) break;
         @(negedge clk);
      end
      check_val("mid_words_before", 64'(q_data.size()), 64'd3);
      rst_n = 1'b0;
      #1;
      check_val("mid_reset_outs", 64'(out_vec()), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      seen_valid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) seen_valid++;
      end
      check_val("mid_no_stale", 64'(seen_valid), 64'd0);
      do_start(18'h00500, 18'd2, t0);
      @(negedge clk);
      start = 1'b0;
      wait_done("mid_new", 50);
      repeat (10) @(negedge clk);
      check_stream("mid_new", 18'h00500, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
